// File: rtl/pll_lock_sequencer.sv
// PLL reset pulse / lock qualification sequencer running on the PLL reference clock.
// Define PLL_SEQ_BYPASS_FALLBACK_EN to release the system on the reference clock after giving up.
module pll_lock_sequencer #(
   parameter int RESET_CYCLES        = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       pll_lock,
   output logic       pll_resetb,
   output logic       pll_bypass,
   output logic       sys_rst_n,
   output logic       locked,
   output logic       fail,
   output logic [3:0] retry_count
);

   localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ? CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RC_M1  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] LS_M1  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       MAXR   = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAIL
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lock_p0;
   logic             lock_p1;
   logic             lock_s;

   assign lock_s = lock_p1;

`ifndef PLL_SEQ_BYPASS_FALLBACK_EN
   assign pll_bypass = 1'b0;
`endif

   // Outputs are updated together with the state so they always match its decode.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         lock_p0     <= 1'b0;
         lock_p1     <= 1'b0;
         state       <= S_RESET;
         cnt         <= '0;
         pll_resetb  <= 1'b0;
         sys_rst_n   <= 1'b0;
         locked      <= 1'b0;
         fail        <= 1'b0;
         retry_count <= 4'd0;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
         pll_bypass  <= 1'b0;
`endif
      end else begin
         lock_p0 <= pll_lock;
         lock_p1 <= lock_p0;

         case (state)
            S_RESET: begin
               if (cnt == RC_M1) begin
                  state      <= S_WAIT_LOCK;
                  cnt        <= '0;
                  pll_resetb <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // Lock is tested first so it wins over a coincident timeout.
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state <= S_STABLE;
                  cnt   <= '0;
               end else if (cnt == TO_M1) begin
                  cnt        <= '0;
                  pll_resetb <= 1'b0;
                  if (retry_count < MAXR) begin
                     retry_count <= retry_count + 4'd1;
                     state       <= S_RESET;
                  end else begin
                     state <= S_FAIL;
                     fail  <= 1'b1;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
                     pll_bypass <= 1'b1;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_STABLE: begin
               if (!lock_s) begin
                  state <= S_WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == LS_M1) begin
                  state       <= S_RUN;
                  cnt         <= '0;
                  sys_rst_n   <= 1'b1;
                  locked      <= 1'b1;
                  retry_count <= 4'd0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_RUN: begin
               if (!lock_s) begin
                  state      <= S_RESET;
                  cnt        <= '0;
                  sys_rst_n  <= 1'b0;
                  locked     <= 1'b0;
                  pll_resetb <= 1'b0;
               end
            end

            S_FAIL: begin
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
               // Counter parks at its terminal value once the system is released.
               if (cnt == RC_M1) begin
                  sys_rst_n <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end

            default: begin
               state <= S_RESET;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
